osc_period_monitor: RTL and testbench
=====================================

// Module: osc_period_monitor
// PURPOSE
//  Receive-side companion to digital_oscillator: samples an oscillator waveform (osc_in),
//  measures period and high time in clk cycles, flags loss of signal and declares frequency
//  lock once consecutive periods agree. Sits after the oscillator output (or an off-chip
//  clock pin) and feeds status/calibration logic.
// PARAMETERS
//  CNT_W        16    width of period/high-time counters and outputs
//  SYNC_STAGES  2     input synchronizer depth (>=2)
//  TIMEOUT_CYC  1000  cycles without an edge before no_signal asserts (< 2**CNT_W-1)
//  LOCK_TOL     2     max |period - previous period| counted as a match
//  LOCK_COUNT   4     consecutive matches required to assert locked
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  rst_n       in   1      asynchronous active-low reset
//  en          in   1      measurement enable
//  osc_in      in   1      oscillator waveform, asynchronous to clk
//  period      out  CNT_W  last measured period (rise-to-rise), clk cycles
//  high_time   out  CNT_W  last measured high time (rise-to-fall), clk cycles
//  meas_valid  out  1      1-cycle pulse: period/high_time updated this cycle
//  no_signal   out  1      level: no edge within TIMEOUT_CYC
//  locked      out  1      level: LOCK_COUNT consecutive matching periods
// BEHAVIOUR
//  - Reset: period=0, high_time=0, meas_valid=0, no_signal=0, locked=0, state IDLE.
//  - osc_in -> SYNC_STAGES flops; rise/fall = sync output differs from its registered copy;
//    edge visible SYNC_STAGES+1 clk after osc_in changes. Latency is identical for both edges.
//  - FSM: IDLE, ARM, HIGH, LOW.
//    IDLE: en=1 -> ARM. ARM: wait first rise (discard partial cycle) -> HIGH, cnt<=1.
//    HIGH: cnt<=cnt+1 each cycle; fall -> hi_cnt<=cnt, LOW.
//    LOW: cnt<=cnt+1; rise -> period<=cnt, high_time<=hi_cnt, meas_valid=1, cnt<=1, HIGH.
//  - Counting: square wave with P-cycle period, H-cycle high time gives period=P, high_time=H.
//    cnt saturates at 2**CNT_W-1, never wraps.
//  - Timeout: separate idle counter, cleared on every edge, runs in ARM/HIGH/LOW; reaching
//    TIMEOUT_CYC -> no_signal=1, locked=0, match count=0, go ARM. no_signal clears on next
//    meas_valid. Timeout and edge in same cycle: edge wins, no timeout.
//  - Lock: on each meas_valid compare new period with previous published period; |diff|<=LOCK_TOL
//    -> match_cnt++ (saturating), else match_cnt=0, locked=0. locked=1 from the cycle
//    match_cnt reaches LOCK_COUNT. First measurement after ARM is never a match.
//  - en=0 in any state: next cycle IDLE, cnt/idle counter/match_cnt cleared, locked=0,
//    no_signal=0, meas_valid=0; period/high_time hold last values.
//  - Async reset mid-measurement: all state/outputs to reset values immediately.
//  - Outputs registered; period/high_time change only in meas_valid cycles.
// STRUCTURE
//  - osc_pkg: state enum (IDLE/ARM/HIGH/LOW), default CNT_W, SYNC_STAGES.
//  - Sub-module osc_edge_sync: synchronizer + rise/fall pulse generation.
//  - Top: FSM, cycle/idle counters, lock comparator, output registers.
// TESTING
//  1. Reset with en=1, osc_in toggling -> all outputs 0 while rst_n=0; ARM after release.
//  2. Square wave period 10, high 4 -> after 2nd rise meas_valid pulses, period=10, high_time=4,
//     repeating every 10 cycles; locked=1 at 5th meas_valid (4 matches).
//  3. Periods 10,11,10,14 with LOCK_TOL=2 -> match_cnt 1,2 then 14 clears locked/match_cnt.
//  4. osc_in stuck high 1000 cycles after lock -> no_signal=1, locked=0; restart wave ->
//     no_signal clears at first new meas_valid.
//  5. en dropped mid-HIGH -> IDLE next cycle, no meas_valid, period holds; en re-raised -> ARM,
//     partial first cycle discarded.
//  6. Period 70000 with CNT_W=16, TIMEOUT_CYC large -> cnt saturates, period=65535, no wrap.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared types and defaults for the oscillator period monitor.
package osc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } osc_state_e;

    localparam int unsigned OSC_CNT_W       = 16;
    localparam int unsigned OSC_SYNC_STAGES = 2;

endpackage

// File: rtl/osc_edge_sync.sv
// Synchronises an asynchronous waveform into the clk domain and emits
// single-cycle rise/fall pulses with identical latency for both edges.
module osc_edge_sync
    import osc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = OSC_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/osc_period_monitor.sv
// Measures period and high time of a sampled oscillator, detects loss of
// signal and declares lock after consecutive matching periods.
module osc_period_monitor
    import osc_pkg::*;
#(
    parameter int unsigned CNT_W       = OSC_CNT_W,
    parameter int unsigned SYNC_STAGES = OSC_SYNC_STAGES,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned LOCK_TOL    = 2,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             osc_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             no_signal,
    output logic             locked
);

    localparam int unsigned      MATCH_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TOL        = CNT_W'(LOCK_TOL);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_COUNT);

    osc_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]   idle_q, idle_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               have_prev_q, have_prev_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic               valid_q, valid_d;
    logic               nosig_q, nosig_d;
    logic               locked_q, locked_d;

    logic               rise, fall;
    logic [CNT_W-1:0]   cnt_inc, idle_inc, diff;
    logic [MATCH_W-1:0] match_inc;
    logic               is_match;

    osc_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .async_i(osc_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign idle_inc  = (idle_q == CNT_MAX) ? idle_q : idle_q + CNT_W'(1);
    assign match_inc = (match_q == MATCH_FULL) ? match_q : match_q + MATCH_W'(1);
    assign diff      = (cnt_q >= period_q) ? cnt_q - period_q : period_q - cnt_q;
    assign is_match  = have_prev_q && (diff <= TOL);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_cnt_d    = hi_cnt_q;
        idle_d      = idle_q;
        match_d     = match_q;
        have_prev_d = have_prev_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        nosig_d     = nosig_q;
        locked_d    = locked_q;

        if (!en) begin
            state_d     = IDLE;
            cnt_d       = '0;
            idle_d      = '0;
            match_d     = '0;
            have_prev_d = 1'b0;
            nosig_d     = 1'b0;
            locked_d    = 1'b0;
        end else if (state_q == IDLE) begin
            state_d     = ARM;
            cnt_d       = '0;
            idle_d      = '0;
            have_prev_d = 1'b0;
        end else if (!(rise || fall) && idle_q == IDLE_LAST) begin
            // An edge in the same cycle keeps us out of this branch.
            state_d     = ARM;
            cnt_d       = '0;
            idle_d      = '0;
            match_d     = '0;
            have_prev_d = 1'b0;
            nosig_d     = 1'b1;
            locked_d    = 1'b0;
        end else begin
            idle_d = (rise || fall) ? '0 : idle_inc;
            unique case (state_q)
                ARM: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
                HIGH: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        hi_cnt_d = cnt_q;
                        state_d  = LOW;
                    end
                end
                LOW: begin
                    cnt_d = cnt_inc;
                    if (rise) begin
                        state_d     = HIGH;
                        cnt_d       = CNT_W'(1);
                        period_d    = cnt_q;
                        high_d      = hi_cnt_q;
                        valid_d     = 1'b1;
                        nosig_d     = 1'b0;
                        have_prev_d = 1'b1;
                        if (is_match) begin
                            match_d  = match_inc;
                            locked_d = (match_inc == MATCH_FULL);
                        end else begin
                            match_d  = '0;
                            locked_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_cnt_q    <= '0;
            idle_q      <= '0;
            match_q     <= '0;
            have_prev_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            nosig_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            idle_q      <= idle_d;
            match_q     <= match_d;
            have_prev_q <= have_prev_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            nosig_q     <= nosig_d;
            locked_q    <= locked_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign no_signal  = nosig_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_osc_period_monitor.sv
// Self-checking bench: table-driven waveforms with a measurement scoreboard,
// plus hand-written timeout, enable, async-reset and saturation sequences.
module tb_osc_period_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        osc = 1'b0;
    logic [15:0] period, high_time;
    logic        meas_valid, no_signal, locked;

    logic        en_b = 1'b0;
    logic        osc_b = 1'b0;
    logic [7:0]  period_b, high_b;
    logic        valid_b, nosig_b, locked_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    osc_period_monitor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .osc_in    (osc),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .no_signal (no_signal),
        .locked    (locked)
    );

    osc_period_monitor #(
        .CNT_W      (8),
        .TIMEOUT_CYC(200)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_b),
        .osc_in    (osc_b),
        .period    (period_b),
        .high_time (high_b),
        .meas_valid(valid_b),
        .no_signal (nosig_b),
        .locked    (locked_b)
    );

    typedef struct {
        logic [15:0] p;
        logic [15:0] h;
        logic        lk;
        logic        ns;
    } exp_t;

    typedef struct {
        int   hi;
        int   lo;
        logic lk;
    } wave_t;

    exp_t sb[$];
    exp_t pend;
    logic have_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Rise that completes the pending cycle: its measurement becomes expected.
    task automatic rise_push();
        osc = 1'b1;
        if (have_prev) sb.push_back(pend);
    endtask

    task automatic wave_cycle(input wave_t w);
        rise_push();
        pend      = '{p: 16'(w.hi + w.lo), h: 16'(w.hi), lk: w.lk, ns: 1'b0};
        have_prev = 1'b1;
        tick(w.hi);
        osc = 1'b0;
        tick(w.lo);
    endtask

    task automatic final_rise();
        rise_push();
        have_prev = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && meas_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_meas_valid: got period %0d expected no pulse at %0t", period, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_period", 64'(period), 64'(e.p));
                chk("sb_high_time", 64'(high_time), 64'(e.h));
                chk("sb_locked", 64'(locked), 64'(e.lk));
                chk("sb_no_signal", 64'(no_signal), 64'(e.ns));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    wave_t lock_tbl[15];
    wave_t restart_tbl[6];
    wave_t p12_tbl[3];

    initial begin
        lock_tbl = '{
            '{4, 6, 1'b0}, '{4, 6, 1'b0}, '{4, 6, 1'b0}, '{4, 6, 1'b0},
            '{4, 6, 1'b1}, '{4, 6, 1'b1}, '{4, 6, 1'b1},
            '{4, 7, 1'b1}, '{4, 6, 1'b1}, '{4, 10, 1'b0}, '{4, 6, 1'b0},
            '{4, 6, 1'b0}, '{4, 6, 1'b0}, '{4, 6, 1'b0}, '{4, 6, 1'b1}
        };
        restart_tbl = '{
            '{4, 6, 1'b0}, '{4, 6, 1'b0}, '{4, 6, 1'b0},
            '{4, 6, 1'b0}, '{4, 6, 1'b1}, '{4, 6, 1'b1}
        };
        p12_tbl = '{'{5, 7, 1'b0}, '{5, 7, 1'b0}, '{5, 7, 1'b0}};

        // Reset held with enable high and a toggling input.
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            osc = ~osc;
            @(negedge clk);
            chk("reset_outputs", {period, high_time, meas_valid, no_signal, locked}, 64'd0);
        end
        osc = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(5);

        // Steady wave to lock, then period drift breaking and regaining lock.
        foreach (lock_tbl[i]) wave_cycle(lock_tbl[i]);
        final_rise();

        // Stuck high: timeout.
        tick(990);
        @(negedge clk);
        chk("pre_timeout_no_signal", 64'(no_signal), 64'd0);
        chk("pre_timeout_locked", 64'(locked), 64'd1);
        begin
            int waited = 0;
            while (!no_signal && waited < 40) begin
                @(negedge clk);
                waited++;
            end
        end
        chk("timeout_no_signal", 64'(no_signal), 64'd1);
        chk("timeout_locked", 64'(locked), 64'd0);

        tick(1);
        osc = 1'b0;
        tick(5);
        @(negedge clk);
        chk("no_signal_held_in_arm", 64'(no_signal), 64'd1);
        tick(1);
        have_prev = 1'b0;
        foreach (restart_tbl[i]) wave_cycle(restart_tbl[i]);
        final_rise();

        // Enable dropped mid-high.
        tick(6);
        en = 1'b0;
        tick(2);
        @(negedge clk);
        chk("en_off_locked", 64'(locked), 64'd0);
        chk("en_off_no_signal", 64'(no_signal), 64'd0);
        chk("en_off_period_hold", 64'(period), 64'd10);
        chk("en_off_high_hold", 64'(high_time), 64'd4);
        tick(2);
        osc = 1'b0;
        tick(4);
        en = 1'b1;
        tick(2);
        have_prev = 1'b0;
        foreach (p12_tbl[i]) wave_cycle(p12_tbl[i]);
        final_rise();
        tick(8);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        // Asynchronous reset between clock edges.
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {period, high_time, meas_valid, no_signal, locked}, 64'd0);
        osc = 1'b0;
        tick(2);
        rst_n = 1'b1;

        // Counter saturation on the narrow instance.
        en_b = 1'b1;
        tick(3);
        for (int k = 0; k < 2; k++) begin
            osc_b = 1'b1;
            tick(150);
            osc_b = 1'b0;
            tick(150);
        end
        osc_b = 1'b1;
        begin
            int waited = 0;
            @(negedge clk);
            while (!valid_b && waited < 20) begin
                @(negedge clk);
                waited++;
            end
        end
        chk("sat_meas_valid", 64'(valid_b), 64'd1);
        chk("sat_period", 64'(period_b), 64'd255);
        chk("sat_high_time", 64'(high_b), 64'd150);
        chk("sat_no_signal", 64'(nosig_b), 64'd0);
        chk("sat_locked_first", 64'(locked_b), 64'd0);

        chk("scoreboard_final", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
